dmem_lsu: RTL



---
 rtl/dmem_lsu.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed data memory with load/store formatting.
// Stores are committed on the accepting edge. Loads read the array on the
// accepting edge and present the sign/zero-extended result one edge later.
// An optional sequential clear zeroes every word after reset.

module dmem_lsu #(
    parameter int unsigned ADDR_W         = 11,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W+1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              illegal;
    logic [3:0]        st_be;
    logic [31:0]       st_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_idx;
    logic [3:0]        mem_be;
    logic [31:0]       mem_din;

    logic [31:0]       rd_word;
    logic              pend_load;
    logic              pend_err;
    logic [1:0]        pend_size;
    logic [1:0]        pend_lane;
    logic              pend_uns;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_fmt;

    // ready is only ever high in IDLE, so it alone qualifies acceptance
    assign accept = req && ready;

    // Alignment and reserved-size detection
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        illegal = 1'b0;
        case (size)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = addr[0];
            2'b10:   illegal = |addr[1:0];
            default: illegal = 1'b1;
        endcase
    end

    // Little-endian lane enables; data is replicated so every lane sees its bytes
    always_comb begin
        st_be   = 4'b0000;
        st_word = wdata;
        case (size)
            2'b00: begin
                st_be[addr[1:0]] = 1'b1;
                st_word          = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_be   = addr[1] ? 4'b1100 : 4'b0011;
                st_word = {2{wdata[15:0]}};
            end
            default: st_be = 4'b1111;
        endcase
    end

    // Single write port shared between the clear sweep and accepted stores
    always_comb begin
        mem_we  = 1'b0;
        mem_idx = addr[ADDR_W+1:2];
        mem_be  = st_be;
        mem_din = st_word;
        if (state == S_CLEAR && !rst) begin
            mem_we  = 1'b1;
            mem_idx = cnt;
            mem_be  = 4'b1111;
            mem_din = '0;
        end else if (accept && we && !illegal) begin
            mem_we = 1'b1;
        end
    end

    // Array write with byte enables, and registered read of the addressed word
    // NOTE: the array has no reset; clearing it is the clear sweep's job, so it maps onto plain RAM.
    always_ff @(posedge clka) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_din[8*i +: 8];
            end
        end
        rd_word <= mem[addr[ADDR_W+1:2]];
    end

    // Select the requested lane and extend it
    always_comb begin
        ld_byte = 8'(rd_word >> {pend_lane, 3'b000});
        ld_half = 16'(rd_word >> {pend_lane[1], 4'b0000});
        case (pend_size)
            2'b00:   ld_fmt = {{24{ld_byte[7] & ~pend_uns}}, ld_byte};
            2'b01:   ld_fmt = {{16{ld_half[15] & ~pend_uns}}, ld_half};
            default: ld_fmt = rd_word;
        endcase
    end

    // Response pipeline: capture the access on acceptance, pulse rvalid/err one edge later
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            pend_load <= 1'b0;
            pend_err  <= 1'b0;
            pend_size <= 2'b00;
            pend_lane <= 2'b00;
            pend_uns  <= 1'b0;
            rvalid    <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            // NOTE: non-blocking assignments let each stage read the previous stage's old value.
            pend_load <= accept && !we && !illegal;
            pend_err  <= accept && illegal;
            if (accept) begin
                pend_size <= size;
                pend_lane <= addr[1:0];
                pend_uns  <= uns;
            end
            rvalid <= pend_load;
            err    <= pend_err;
            if (pend_load) rdata <= ld_fmt;
        end
    end

    // Clear/idle FSM; ready trails the state by one edge
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            ready <= (state == S_IDLE);
            case (state)
                S_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
